fxp_pipelined_addsub: RTL
=========================

FXP_PIPELINED_ADDSUB -- requirements
Module: fxp_pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (two's-complement fixed point).
REQ-002 SHALL have parameter SEG, default 4, carry-select segment width; WIDTH % SEG != 0 or SEG > WIDTH is an elaboration error.
REQ-003 SHALL have ports, in order:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of MSB (raw adder carry).
- overflow  output  1  signed overflow.
- negative  output  1  MSB of result as driven.
- zero  output  1  result as driven equals 0.

Function
REQ-004 SHALL form operand B' = sub ? ~b : b and effective carry-in = cin XOR sub.
REQ-005 SHALL split the add into STAGES = WIDTH/SEG carry-select segments, least significant first, with one register stage after each segment. Each segment computes both carry-in cases and muxes on the previous stage's carry.
REQ-006 SHALL have latency of exactly STAGES cycles from an accepted beat (in_valid & in_ready) to its out_valid when no stall occurs.
REQ-007 SHALL carry the upper unprocessed operand bits and sub/valid alongside each stage so results stay in order, with one beat per stage.
REQ-008 SHALL use a global pipeline enable: advance = !out_valid | out_ready; in_ready = advance.
REQ-009 SHALL hold every stage (data and valid) unchanged while advance = 0; no beat lost or duplicated.
REQ-010 SHALL accept one beat per cycle at full throughput when out_ready stays 1; bubbles propagate as invalid stages.
REQ-011 SHALL compute overflow = carry into MSB XOR carry out of MSB.
REQ-012 SHALL drive cout as the raw MSB carry, never saturated.
REQ-013 SHALL keep result, cout, overflow, negative and zero stable while out_valid = 1 and out_ready = 0.
REQ-014 SHALL have don't-care result/flag values when out_valid = 0, but they must be held, not toggled.

Reset
REQ-015 SHALL, on rst = 1, asynchronously clear all stage valid bits, out_valid, result, cout, overflow, negative and zero to 0. While rst is held, zero reads 0.
REQ-016 SHALL drop beats in flight when rst asserts mid-operation; the first accepted beat after rst deasserts appears STAGES cycles later.
REQ-017 SHALL drive in_ready = 1 in the first cycle after reset.

Configuration
REQ-018 SHALL, when macro FXP_ADDSUB_SAT_EN is defined, saturate on overflow: result = 0111..1 if A's sign is 0, else 1000..0. The overflow flag stays 1 and negative/zero reflect the saturated value.
REQ-019 SHALL, when FXP_ADDSUB_SAT_EN is undefined, output the wrapped two's-complement result with the same flags and latency.

Structure
REQ-020 SHALL place default WIDTH/SEG constants and the saturation constants (max-positive/min-negative generators) in shared package fxp_pkg.
REQ-021 SHALL instantiate sub-module carry_select_segment (SEG-bit, inputs x, y, c_in; outputs sum, c_out, c_msb_in), once per stage.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-022 SHALL test add: a=0x1234, b=0x0FED, cin=0, sub=0 -> result 0x2221, cout=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-023 SHALL test positive overflow: a=0x7FFF, b=0x0001, sub=0 -> overflow=1, cout=0; result 0x8000, or 0x7FFF with FXP_ADDSUB_SAT_EN.
REQ-024 SHALL test sub with borrow: a=0x0005, b=0x0005, cin=1, sub=1 -> result 0xFFFF, negative=1, zero=0, cout=0; a=b=0x8000, cin=0, sub=1 -> result 0, zero=1, cout=1.
REQ-025 SHALL test back-to-back stall: stream 8 beats a=i, b=i; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, outputs 2i in order, no loss or duplicate.
REQ-026 SHALL test reset mid-flight: assert rst with 3 beats in flight -> out_valid=0 immediately, no stale beat after release.
REQ-027 SHALL test negative overflow: a=0x8000, b=0x0001, sub=1 -> overflow=1, cout=1; result 0x7FFF wrapped, or 0x8000 saturated.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared constants for the fixed-point add/sub pipeline: default geometry,
// operation encoding and the saturation value generators.
package fxp_pkg;

    localparam int FXP_WIDTH_DEFAULT = 16;
    localparam int FXP_SEG_DEFAULT   = 4;
    localparam int FXP_MAX_WIDTH     = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fxp_op_e;

    // Largest positive two's-complement value of width w: 0111..1.
    function automatic logic [FXP_MAX_WIDTH-1:0] fxp_max_pos(input int w);
        return (FXP_MAX_WIDTH'(1) << (w - 1)) - FXP_MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of width w: 1000..0.
    function automatic logic [FXP_MAX_WIDTH-1:0] fxp_min_neg(input int w);
        return FXP_MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/carry_select_segment.sv
// One SEG-bit carry-select slice: both carry-in sums are formed in parallel
// and the real carry picks one; also exposes the carry into the slice MSB.
module carry_select_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [SEG:0] sum_c0;
    logic [SEG:0] sum_c1;

    assign sum_c0 = {1'b0, x} + {1'b0, y};
    assign sum_c1 = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, 1'b1};

    assign {c_out, sum} = c_in ? sum_c1 : sum_c0;

    // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb_in = x[SEG-1] ^ y[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/fxp_pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, one carry-select segment per stage.
// Define FXP_ADDSUB_SAT_EN to saturate the result on signed overflow.
module fxp_pipelined_addsub
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH_DEFAULT,
    parameter int SEG   = FXP_SEG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;

    if ((SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("fxp_pipelined_addsub: WIDTH must be a multiple of SEG and SEG <= WIDTH");
    end

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             overflow_q;
    logic             negative_q;
    logic             zero_q;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign zero      = zero_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * SEG;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]    x_in;
        logic [REM-1:0]    y_in;
        logic              c_in;
        logic              v_in;
        logic [LO+SEG-1:0] part_sum;
        logic [SEG-1:0]    seg_sum;
        logic              seg_cout;
        logic              seg_cmsb;

        carry_select_segment #(.SEG(SEG)) u_seg (
            .x        (x_in[SEG-1:0]),
            .y        (y_in[SEG-1:0]),
            .c_in     (c_in),
            .sum      (seg_sum),
            .c_out    (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        if (gi == 0) begin : g_src
            assign x_in     = a;
            assign y_in     = (sub == OP_SUB) ? ~b : b;
            assign c_in     = cin ^ sub;
            assign v_in     = in_valid;
            assign part_sum = seg_sum;
        end else begin : g_src
            assign x_in     = g_stage[gi-1].g_pipe.x_q;
            assign y_in     = g_stage[gi-1].g_pipe.y_q;
            assign c_in     = g_stage[gi-1].g_pipe.c_q;
            assign v_in     = g_stage[gi-1].g_pipe.v_q;
            assign part_sum = {seg_sum, g_stage[gi-1].g_pipe.sum_q};
        end

        if (gi < STAGES - 1) begin : g_pipe
            logic               v_q;
            logic               c_q;
            logic [LO+SEG-1:0]  sum_q;
            logic [REM-SEG-1:0] x_q;
            logic [REM-SEG-1:0] y_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_in;
                end
            end

            // Data only loads real beats, so bubbles leave the stage contents untouched.
            always_ff @(posedge clk) begin
                if (advance && v_in) begin
                    c_q   <= seg_cout;
                    sum_q <= part_sum;
                    x_q   <= x_in[REM-1:SEG];
                    y_q   <= y_in[REM-1:SEG];
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] result_d;
            logic             overflow_d;

            assign overflow_d = seg_cmsb ^ seg_cout;
`ifdef FXP_ADDSUB_SAT_EN
            localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(fxp_max_pos(WIDTH));
            localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(fxp_min_neg(WIDTH));

            // The top segment of x_in is A's top segment, so its MSB is A's sign.
            assign result_d = !overflow_d ? part_sum : (x_in[SEG-1] ? SAT_NEG : SAT_POS);
`else
            assign result_d = part_sum;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    result_q    <= '0;
                    cout_q      <= 1'b0;
                    overflow_q  <= 1'b0;
                    negative_q  <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= v_in;
                    if (v_in) begin
                        result_q   <= result_d;
                        cout_q     <= seg_cout;
                        overflow_q <= overflow_d;
                        negative_q <= result_d[WIDTH-1];
                        zero_q     <= (result_d == '0);
                    end
                end
            end
        end
    end

endmodule
